pmem_responder: RTL

Physical-memory responder for the cache-to-memory line interface: it accepts one 256-bit line read or write request at a time from the cache controller and completes it after a fixed, parameterised latency with a single-cycle `pmem_resp` pulse. It holds a synthesizable backing store of whole cache lines. It sits below the cache controller and replaces the behavioural memory model in simulation and FPGA bring-up.

---
 rtl/pmem_types_pkg.sv | 25 ++
 rtl/pmem_line_array.sv | 50 +++++
 rtl/pmem_responder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pmem_types_pkg.sv
// ---------------------------------------------------------------------------
// pmem_types_pkg
// Shared types and constants for the physical-memory responder slice.
//   LINE_BITS   : width of one cache line moved per request
//   OFFSET_BITS : byte-offset bits inside a line, ignored by the responder
//   state_t     : responder sequencing states
//   pmem_op_t   : latched operation kind
// ---------------------------------------------------------------------------
package pmem_types_pkg;

    localparam int LINE_BITS   = 256;
    localparam int OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        s_idle,
        s_busy,
        s_resp
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } pmem_op_t;

endpackage

// File: rtl/pmem_line_array.sv
// ---------------------------------------------------------------------------
// pmem_line_array
// Single-port backing store of whole cache lines with a registered read port.
// Ports:
//   clk       : clock, all activity on the rising edge
//   rst_n     : synchronous active-low reset, clears only the read register
//   addr_i    : line index shared by the read and write paths
//   wrEn_i    : write the line at addr_i with wrData_i
//   wrData_i  : line to store
//   rdEn_i    : load the read register from the line at addr_i
//   rdData_o  : registered read line, held until the next rdEn_i
// ---------------------------------------------------------------------------
module pmem_line_array
    import pmem_types_pkg::*;
#(
    parameter int DEPTH_LINES = 64,
    localparam int IDX_W = $clog2(DEPTH_LINES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     addr_i,
    input  logic                 wrEn_i,
    input  logic [LINE_BITS-1:0] wrData_i,
    input  logic                 rdEn_i,
    output logic [LINE_BITS-1:0] rdData_o
);

    logic [LINE_BITS-1:0] mem [DEPTH_LINES];
    logic [LINE_BITS-1:0] rdData_q;

    // Storage itself is never reset so line contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem[addr_i] <= wrData_i;
        end
    end

    // The read register only moves on an explicit load, so the last read line
    // stays visible to the cache until the next read completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= mem[addr_i];
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: rtl/pmem_responder.sv
// ---------------------------------------------------------------------------
// pmem_responder
// Physical-memory responder for the cache line interface. Serves one 256-bit
// line read or write at a time and completes it after LATENCY cycles with a
// one-cycle pmem_resp pulse, backed by a synthesizable line array.
// Parameters:
//   LATENCY      : cycles from first sampling a request to pmem_resp (>= 1)
//   DEPTH_LINES  : lines in the backing store (power of two, >= 2)
// Ports:
//   clk          : clock
//   rst_n        : synchronous active-low reset
//   pmem_read    : read request, held until pmem_resp
//   pmem_write   : write request, held until pmem_resp
//   pmem_address : byte address, bits [4:0] ignored, upper bits wrap
//   pmem_wdata   : write line, captured in the first request cycle
//   pmem_rdata   : read line, valid with pmem_resp and held until next read
//   pmem_resp    : one-cycle completion pulse
//   proto_err    : sticky protocol-violation flag
// ---------------------------------------------------------------------------
module pmem_responder
    import pmem_types_pkg::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_LINES = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pmem_read,
    input  logic                 pmem_write,
    input  logic [31:0]          pmem_address,
    input  logic [LINE_BITS-1:0] pmem_wdata,
    output logic [LINE_BITS-1:0] pmem_rdata,
    output logic                 pmem_resp,
    output logic                 proto_err
);

    localparam int IDX_W = $clog2(DEPTH_LINES);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t               state_q;
    logic [CNT_W-1:0]     cnt_q;
    pmem_op_t             op_q;
    logic [IDX_W-1:0]     lineIdx_q;
    logic [LINE_BITS-1:0] wdata_q;
    logic                 protoErr_q;

    logic [IDX_W-1:0]     reqIdx;
    pmem_op_t             reqOp;
    logic                 startReq;
    logic                 bothReq;
    logic                 abortReq;
    logic                 enterResp;
    logic                 arrayRdEn;
    logic                 arrayWrEn;
    logic [IDX_W-1:0]     arrayAddr;
    logic                 unusedAddrBits;

    assign unusedAddrBits = ^{pmem_address[31:OFFSET_BITS+IDX_W],
                              pmem_address[OFFSET_BITS-1:0]};

    // Request decode and array control. A busy transfer is abandoned as soon
    // as its own request line drops or the opposite one rises; abort wins over
    // the final countdown step so an aborted read never loads pmem_rdata.
    // While idle the array is addressed straight from the bus so a LATENCY==1
    // read can load on the very edge that accepts it; otherwise the latched
    // index is used, which is also what the write on leaving RESP needs.
    always_comb begin
        reqIdx    = pmem_address[OFFSET_BITS +: IDX_W];
        reqOp     = pmem_write ? OP_WRITE : OP_READ;
        startReq  = (state_q == s_idle) && (pmem_read ^ pmem_write);
        bothReq   = (state_q == s_idle) && pmem_read && pmem_write;
        abortReq  = 1'b0;
        if (state_q == s_busy) begin
            if (op_q == OP_READ) begin
                abortReq = !pmem_read || pmem_write;
            end else begin
                abortReq = !pmem_write || pmem_read;
            end
        end
        enterResp = (startReq && (LATENCY == 1)) ||
                    ((state_q == s_busy) && !abortReq && (cnt_q == CNT_ONE));
        arrayRdEn = enterResp &&
                    ((state_q == s_idle) ? (reqOp == OP_READ) : (op_q == OP_READ));
        arrayWrEn = rst_n && (state_q == s_resp) && (op_q == OP_WRITE);
        arrayAddr = (state_q == s_idle) ? reqIdx : lineIdx_q;
    end

    // Sequencer: IDLE accepts exactly one request kind, BUSY counts down the
    // remaining latency, RESP lasts one cycle and always returns to IDLE, so
    // request lines still held during RESP are never taken as a new request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= s_idle;
            cnt_q      <= '0;
            op_q       <= OP_READ;
            lineIdx_q  <= '0;
            wdata_q    <= '0;
            protoErr_q <= 1'b0;
        end else begin
            case (state_q)
                s_idle: begin
                    if (bothReq) begin
                        protoErr_q <= 1'b1;
                    end else if (startReq) begin
                        op_q      <= reqOp;
                        lineIdx_q <= reqIdx;
                        wdata_q   <= pmem_wdata;
                        if (LATENCY == 1) begin
                            state_q <= s_resp;
                        end else begin
                            state_q <= s_busy;
                            cnt_q   <= CNT_START;
                        end
                    end
                end
                s_busy: begin
                    if (abortReq) begin
                        state_q    <= s_idle;
                        cnt_q      <= '0;
                        protoErr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                        if (cnt_q == CNT_ONE) begin
                            state_q <= s_resp;
                        end
                    end
                end
                s_resp: begin
                    state_q <= s_idle;
                end
                default: begin
                    state_q <= s_idle;
                end
            endcase
        end
    end

    pmem_line_array #(
        .DEPTH_LINES(DEPTH_LINES)
    ) lineArray (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr_i   (arrayAddr),
        .wrEn_i   (arrayWrEn),
        .wrData_i (wdata_q),
        .rdEn_i   (arrayRdEn),
        .rdData_o (pmem_rdata)
    );

    assign pmem_resp = (state_q == s_resp);
    assign proto_err = protoErr_q;

endmodule
